// File: rtl/timer_ctl_param_pkg.sv
// Shared definitions for the countdown-timer controller: one-hot state encoding,
// counter widths and the field-index stepping helper.
package timer_ctl_param_pkg;

  localparam int unsigned StateW = 4;
  localparam int unsigned CntW   = 16;
  localparam int unsigned IdxW   = 3;

  // One-hot so the state register can drive the debug LEDs directly.
  typedef enum logic [StateW-1:0] {
    StIdle     = 4'b0001,
    StSetup    = 4'b0010,
    StCounting = 4'b0100,
    StAlarm    = 4'b1000
  } state_e;

  // Step to the next less-significant field, wrapping 0 back to the top field.
  function automatic logic [IdxW-1:0] prev_field(input logic [IdxW-1:0] idx,
                                                  input int unsigned   num_fields);
    return (idx == '0) ? IdxW'(num_fields - 1) : idx - IdxW'(1);
  endfunction

endpackage

// File: rtl/timer_ctl_param_if.sv
// Control bundle between the button front end / field datapath and the timer controller.
// master: the controller; slave: the surrounding front end and datapath.
interface timer_ctl_param_if #(
  parameter int unsigned NUM_FIELDS = 3
) ();
  import timer_ctl_param_pkg::*;

  logic                  tick;
  logic                  trig;
  logic                  set;
  logic                  up;
  logic                  down;
  logic                  complete;
  logic                  init_regs;
  logic                  count_enabled;
  logic                  inc;
  logic                  dec;
  logic [NUM_FIELDS-1:0] field_sel;
  logic                  alarm;
  logic [StateW-1:0]     state;

  modport master (
    input  tick, trig, set, up, down, complete,
    output init_regs, count_enabled, inc, dec, field_sel, alarm, state
  );

  modport slave (
    output tick, trig, set, up, down, complete,
    input  init_regs, count_enabled, inc, dec, field_sel, alarm, state
  );

endinterface

// File: rtl/timer_ctl_param_btn_repeat.sv
// Auto-repeat engine for one held button: a pulse on the press, then one after
// REPEAT_DELAY ticks and every REPEAT_RATE ticks while still held.
module timer_ctl_param_btn_repeat
  import timer_ctl_param_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic enable,
  input  logic level,
  input  logic block,
  output logic pulse
);

  localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);

  logic            level_q, level_d;
  logic            armed_q, armed_d;
  logic            first_q, first_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next-state: level_q tracks the button even when disabled so a level already
  // high on SETUP entry never looks like a fresh press.
  always_comb begin
    level_d = level;
    pulse_d = 1'b0;
    armed_d = armed_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    if (!enable || !level || block) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (!level_q) begin
      pulse_d = 1'b1;
      armed_d = 1'b1;
      first_d = 1'b1;
      cnt_d   = '0;
    end else if (armed_q && tick) begin
      if (cnt_q == (first_q ? DelayLast : RateLast)) begin
        pulse_d = 1'b1;
        first_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
      first_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      armed_q <= armed_d;
      first_q <= first_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/timer_ctl_param.sv
// Countdown-timer controller: IDLE/SETUP/COUNTING/ALARM sequencing, field selection
// for editing, auto-repeat inc/dec and the alarm timeout.
module timer_ctl_param
  import timer_ctl_param_pkg::*;
#(
  parameter int unsigned NUM_FIELDS   = 3,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned ALARM_TICKS  = 5000
) (
  input logic               clk,
  input logic               reset,
  timer_ctl_param_if.master bus
);

  localparam logic [IdxW-1:0]       LastIdx   = IdxW'(NUM_FIELDS - 1);
  localparam logic [CntW-1:0]       AlarmLast = CntW'(ALARM_TICKS - 1);
  localparam logic [NUM_FIELDS-1:0] SelLsb    = NUM_FIELDS'(1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [CntW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic            in_setup;
  logic            up_pulse;
  logic            down_pulse;
  logic            any_btn;

  assign in_setup = (state_q == StSetup);
  assign any_btn  = bus.trig | bus.set | bus.up | bus.down;

  // Each engine is blocked by the other direction so both held yields nothing.
  timer_ctl_param_btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_up_repeat (
    .clk   (clk),
    .reset (reset),
    .tick  (bus.tick),
    .enable(in_setup),
    .level (bus.up),
    .block (bus.down),
    .pulse (up_pulse)
  );

  timer_ctl_param_btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_down_repeat (
    .clk   (clk),
    .reset (reset),
    .tick  (bus.tick),
    .enable(in_setup),
    .level (bus.down),
    .block (bus.up),
    .pulse (down_pulse)
  );

  // Next-state for the FSM, edited field index and alarm timeout counter.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    alarm_cnt_d = alarm_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.set) begin
          state_d = StSetup;
          idx_d   = LastIdx;
        end
      end
      StSetup: begin
        // A run is refused while the datapath already reads zero.
        if (bus.trig) begin
          if (!bus.complete) state_d = StCounting;
        end else if (bus.set) begin
          idx_d = prev_field(idx_q, NUM_FIELDS);
        end
      end
      StCounting: begin
        if (bus.complete) begin
          state_d     = StAlarm;
          alarm_cnt_d = '0;
        end else if (bus.trig) begin
          state_d = StSetup;
          idx_d   = LastIdx;
        end
      end
      StAlarm: begin
        if (any_btn) begin
          state_d = StIdle;
        end else if (bus.tick) begin
          if (alarm_cnt_q == AlarmLast) state_d = StIdle;
          else alarm_cnt_d = alarm_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= LastIdx;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.init_regs = (state_q == StIdle);
  assign bus.alarm     = (state_q == StAlarm);
  assign bus.field_sel = in_setup ? (SelLsb << idx_q) : '0;
  // Pausing trig suppresses the decrement in the same cycle.
  assign bus.count_enabled = (state_q == StCounting) & ~bus.complete & ~bus.trig;
  // Drop a pulse that lands on the edge leaving SETUP.
  assign bus.inc = up_pulse & in_setup;
  assign bus.dec = down_pulse & in_setup;

endmodule
